// File: rtl/arb_pkg.sv
// Shared definitions for the BRAM port arbiter.
//   arb_state_e : arbiter FSM encoding (IDLE -> BURST -> DONE -> IDLE)
//   idx_w/beat_w: widths of the requester index and beat counter; modules
//                 turn these into their IDX_WIDTH / BEAT_WIDTH localparams
//                 because a package cannot see a module's parameters.
package arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } arb_state_e;

  function automatic int idx_w(input int num_req);
    return (num_req < 2) ? 1 : $clog2(num_req);
  endfunction

  function automatic int beat_w(input int burst_len);
    return (burst_len < 2) ? 1 : $clog2(burst_len);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker.
//   req     : request vector
//   ptr     : index where the scan starts (wraps past NUM_REQ-1)
//   win     : one-hot winner (0 when no request)
//   win_idx : binary index of the winner
//   any_req : at least one request is set
module rr_priority_picker #(
  parameter int NUM_REQ   = 4,
  parameter int IDX_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]   win,
  output logic [IDX_WIDTH-1:0] win_idx,
  output logic                 any_req
);

  int j;

  // Scan from the farthest offset back to offset 0, so the closest set bit
  // at or after ptr is the last one written and therefore wins.
  always_comb begin
    win     = '0;
    win_idx = '0;
    any_req = |req;
    j       = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (req[IDX_WIDTH'(j)]) begin
        win                 = '0;
        win[IDX_WIDTH'(j)]  = 1'b1;
        win_idx             = IDX_WIDTH'(j);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM among NUM_REQ requesters.
// Each grant is a fixed BURST_LEN-beat read or write burst.
//   req/req_we/req_addr : per-requester level request, direction, base address
//   req_wdata           : per-requester write data, muxed by the current owner
//   gnt/done            : one-hot beat grant, one-cycle completion pulse
//   mem_*               : BRAM port (1-cycle read latency on mem_rdata)
//   rdata/rdata_valid/rdata_id : read data returned to the burst owner
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int BURST_LEN  = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            done,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  input  logic [DATA_WIDTH-1:0]         mem_rdata,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          rdata_valid,
  output logic [$clog2(NUM_REQ)-1:0]    rdata_id
);

  localparam int IDX_WIDTH  = idx_w(NUM_REQ);
  localparam int BEAT_WIDTH = beat_w(BURST_LEN);

  arb_state_e            state, state_n;
  logic [IDX_WIDTH-1:0]  idx, idx_n, ptr, ptr_n, win_idx;
  logic [BEAT_WIDTH-1:0] beat, beat_n;
  logic [NUM_REQ-1:0]    win, gnt_n, done_n;
  logic                  any_req, mem_en_n, mem_we_n, rd_vld_n;
  logic [ADDR_WIDTH-1:0] mem_addr_n;
  logic [IDX_WIDTH-1:0]  rd_id_n;

  rr_priority_picker #(
    .NUM_REQ  (NUM_REQ),
    .IDX_WIDTH(IDX_WIDTH)
  ) u_picker (
    .req    (req),
    .ptr    (ptr),
    .win    (win),
    .win_idx(win_idx),
    .any_req(any_req)
  );

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    ptr_n      = ptr;
    beat_n     = beat;
    gnt_n      = gnt;
    done_n     = '0;
    mem_en_n   = mem_en;
    mem_we_n   = mem_we;
    mem_addr_n = mem_addr;
    unique case (state)
      ST_IDLE: begin
        if (any_req) begin
          state_n    = ST_BURST;
          idx_n      = win_idx;
          beat_n     = '0;
          gnt_n      = win;
          mem_en_n   = 1'b1;
          mem_we_n   = req_we[win_idx];
          mem_addr_n = req_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        end
      end
      ST_BURST: begin
        if (beat == BEAT_WIDTH'(BURST_LEN - 1)) begin
          state_n  = ST_DONE;
          gnt_n    = '0;
          mem_en_n = 1'b0;
          mem_we_n = 1'b0;
          done_n   = gnt;
          ptr_n    = IDX_WIDTH'((int'(idx) + 1) % NUM_REQ);
        end else begin
          beat_n     = beat + 1'b1;
          // base+beat is tracked incrementally; the address wraps silently
          mem_addr_n = mem_addr + 1'b1;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Read data comes back one cycle after each read beat.
  assign rd_vld_n = mem_en & ~mem_we;
  assign rd_id_n  = rd_vld_n ? idx : rdata_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      idx         <= '0;
      ptr         <= '0;
      beat        <= '0;
      gnt         <= '0;
      done        <= '0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      rdata_valid <= 1'b0;
      rdata_id    <= '0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      ptr         <= ptr_n;
      beat        <= beat_n;
      gnt         <= gnt_n;
      done        <= done_n;
      mem_en      <= mem_en_n;
      mem_we      <= mem_we_n;
      mem_addr    <= mem_addr_n;
      rdata_valid <= rd_vld_n;
      rdata_id    <= rd_id_n;
    end
  end

  assign mem_wdata = req_wdata[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
  assign rdata     = mem_rdata;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port data BRAM among NUM_REQ requesters: router read path, DFX receive write path, and local compute ports.
- Each request is a fixed-length burst, either read or write, starting at a requester-supplied base address.
- Winners are chosen round-robin. The block sequences the BRAM enable, write-enable and address, and steers read data back to the winner.
- It sits between the router controllers and the BRAM, and is the provider of the read_gnt/write_gnt handshake.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 10, BRAM address width.
- DATA_WIDTH, 64, BRAM/Aurora data width.
- BURST_LEN, 5, beats per granted burst (2..16).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req  in  NUM_REQ  per-requester burst request, level
- req_we  in  NUM_REQ  1=write burst, 0=read burst; sampled at grant
- req_addr  in  NUM_REQ*ADDR_WIDTH  base addresses; slice i belongs to requester i
- req_wdata  in  NUM_REQ*DATA_WIDTH  write data; slice i valid while gnt[i] high
- gnt  out  NUM_REQ  one-hot; high on every beat cycle of the winner's burst
- done  out  NUM_REQ  one-cycle pulse to the winner after its last beat
- mem_en  out  1  BRAM enable
- mem_we  out  1  BRAM write enable
- mem_addr  out  ADDR_WIDTH  BRAM address
- mem_wdata  out  DATA_WIDTH  BRAM write data
- mem_rdata  in  DATA_WIDTH  BRAM read data; 1-cycle read latency
- rdata  out  DATA_WIDTH  returned read data
- rdata_valid  out  1  rdata qualifier
- rdata_id  out  $clog2(NUM_REQ)  index of the requester that owns rdata

Behaviour:
- Reset values: gnt, done, mem_en, mem_we, mem_addr, rdata_valid, rdata_id = 0. State = IDLE. Beat counter = 0. RR pointer = 0.
- FSM states: IDLE, BURST, DONE.
- IDLE: when any req bit is high, select the winner and latch its index, req_we bit and req_addr slice. Next state is BURST. If no req bit is high, stay in IDLE.
- Winner selection: scan starts at the RR pointer and wraps; the first set bit wins. After reset the pointer is 0.
- Registered outputs: gnt[idx], mem_en, mem_we (=latched we) and mem_addr (=base+beat) all go high/valid at the same clock edge that enters BURST. Grant latency is therefore 1 cycle from req sampled in IDLE.
- BURST: lasts exactly BURST_LEN cycles. The beat counter runs 0..BURST_LEN-1. On the last beat the next state is DONE.
- mem_addr = (base + beat) mod 2^ADDR_WIDTH; wrap past max address is silent.
- mem_wdata is a combinational mux of req_wdata[idx]. A requester must present beat k data in the k-th cycle its gnt is high.
- Read bursts: rdata_valid is high one cycle after each read beat. rdata = mem_rdata, rdata_id = idx. This gives exactly BURST_LEN valid cycles.
- Write bursts: rdata_valid stays 0.
- DONE: gnt and mem_en are 0. done[idx] pulses for 1 cycle. RR pointer = (idx+1) mod NUM_REQ. Next state is IDLE.
- Bus occupancy: a burst occupies BURST_LEN+2 cycles from grant to the next possible grant (BURST, DONE, IDLE arbitration).
- Bursts are never aborted. If req drops mid-burst, the burst still completes and done still pulses.
- Changes to req_addr or req_we after grant are ignored until the next arbitration.
- Simultaneous requests: round-robin decides. A requester holding req high after its done loses to any other waiting requester. With a single requester, back-to-back bursts are granted every BURST_LEN+2 cycles.
- Reset asserted mid-burst: immediate return to reset values. The partial burst is lost and no done pulse is issued.
- Invariants: at most one gnt bit set; gnt ≠ 0 ⇔ mem_en=1.

Decomposition:
- Shared package arb_pkg: FSM state encoding (IDLE/BURST/DONE), IDX_WIDTH = $clog2(NUM_REQ), BEAT_WIDTH = $clog2(BURST_LEN).
- One sub-module, rr_priority_picker: combinational; inputs req vector and pointer; outputs one-hot winner, winner index and any_req.

Test Plan:
- Single read: req=0001, req_addr[0]=10'h020, req_we=0 -> gnt[0] high cycles 1..5. mem_addr 0x020..0x024. rdata_valid cycles 2..6 with rdata_id=0. done[0] pulses in cycle 6.
- Contention: req=1111 held after reset -> grant order 0,1,2,3,0. Grants spaced 7 cycles. Never two gnt bits high.
- Write burst: req=0100, req_we[2]=1, req_addr[2]=10'h3FE, wdata incrementing -> mem_we=1 on 5 beats. mem_addr 3FE, 3FF, 000, 001, 002 (wrap). rdata_valid never set.
- Req drop: req[1] deasserted in beat 2 -> all 5 beats still issued and done[1] pulses. The next arbitration excludes requester 1.
- Reset mid-burst: rst_n low during beat 3 -> all outputs 0 immediately. After release, req=0010 is granted to requester 1 (pointer back to 0, so scan starts at 0).
- Fairness: req[0] held permanently, req[3] asserted during requester 0's burst -> requester 3 wins the next arbitration.
